// File: rtl/mips_trace_buffer.sv
// Execution-trace capture for single_cycle_mips: circular commit buffer, PC trigger, post-trigger window.
// Oldest-first combinational read port; capture state frozen in DONE until the next arm.
module mips_trace_buffer #(
  parameter int PC_WIDTH       = 10,
  parameter int INST_WIDTH     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DEPTH          = 16,
  parameter int POST_TRIG      = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [PC_WIDTH-1:0]        pc,
  input  logic [INST_WIDTH-1:0]      instruction,
  input  logic                       reg_write,
  input  logic [REG_ADDR_WIDTH-1:0]  write_reg,
  input  logic [DATA_WIDTH-1:0]      write_back,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       trig_en,
  input  logic [PC_WIDTH-1:0]        trig_pc,
  input  logic                       filter_wb,
  input  logic [$clog2(DEPTH)-1:0]   rd_index,
  output logic [PC_WIDTH-1:0]        rd_pc,
  output logic [INST_WIDTH-1:0]      rd_inst,
  output logic                       rd_wb_en,
  output logic [REG_ADDR_WIDTH-1:0]  rd_wb_reg,
  output logic [DATA_WIDTH-1:0]      rd_wb_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic [$clog2(DEPTH)-1:0]   trig_pos
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_WIDTH + INST_WIDTH + 1 + REG_ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_trig_slot;
  logic [AW-1:0]   r_post_left;
  logic [AW:0]     r_count;
  logic            r_triggered;

  logic            w_qual;
  logic            w_hit;
  logic            w_capture;
  logic            w_trig_take;
  logic [AW-1:0]   w_oldest;
  logic [AW-1:0]   w_rd_addr;
  logic [EW-1:0]   w_rd_entry;

  assign w_qual = !filter_wb || reg_write;
  assign w_hit  = trig_en && (pc == trig_pc);

  // arm outranks abort, and abort outranks a trigger hit
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_trig_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (arm) begin
          w_state_nxt = S_ARMED;
        end else if (abort) begin
          w_state_nxt = S_DONE;
        end else begin
          w_capture = w_qual || w_hit;
          if (w_hit) begin
            w_trig_take = 1'b1;
            w_state_nxt = (POST_TRIG == 0) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (arm) begin
          w_state_nxt = S_ARMED;
        end else if (abort) begin
          w_state_nxt = S_DONE;
        end else if (w_qual) begin
          w_capture = 1'b1;
          if (r_post_left == AW'(1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (arm) w_state_nxt = S_ARMED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_triggered <= 1'b0;
      r_trig_slot <= '0;
      r_post_left <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (arm) begin
        r_count     <= '0;
        r_wr_ptr    <= '0;
        r_triggered <= 1'b0;
        r_trig_slot <= '0;
        r_post_left <= '0;
      end else if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_count != (AW+1)'(DEPTH)) r_count <= r_count + (AW+1)'(1);
        if (w_trig_take) begin
          r_triggered <= 1'b1;
          r_trig_slot <= r_wr_ptr;
          r_post_left <= AW'(POST_TRIG);
        end else if (r_state == S_POST) begin
          r_post_left <= r_post_left - AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && w_capture)
      r_mem[r_wr_ptr] <= {pc, instruction, reg_write, write_reg, write_back};
  end

  // Until the buffer wraps, slot 0 holds the oldest entry; afterwards wr_ptr does
  assign w_oldest   = (r_count == (AW+1)'(DEPTH)) ? r_wr_ptr : '0;
  assign w_rd_addr  = w_oldest + rd_index;
  assign w_rd_entry = r_mem[w_rd_addr];

  assign {rd_pc, rd_inst, rd_wb_en, rd_wb_reg, rd_wb_data} = w_rd_entry;
  assign rd_valid  = ({1'b0, rd_index} < r_count);
  assign count     = r_count;
  assign state     = r_state;
  assign triggered = r_triggered;
  assign trig_pos  = r_triggered ? (r_trig_slot - w_oldest) : '0;

endmodule
